// File: rtl/carrega_operandos_if.sv
// ---------------------------------------------------------------------------
// carrega_operandos_if
//   Bundles the board-facing and adder-facing signals of carrega_operandos.
//   Clock and reset are kept as plain ports on the module.
//
//   Signals:
//     sw        switch value (asynchronous to clk)
//     btn       load key, active high, level
//     clr       synchronous clear, already in the clk domain
//     soma_in   sum returned by the external combinational adder
//     a, b      registered operands driven to the adder
//     resultado registered sum
//     carry     registered carry-out of a+b
//     valid     result qualifier (see below)
//     estado    current FSM state code
//     erro      adder self-check flag (only with SOMA_CHECK_EN)
//
//   valid semantics: valid is a level, not a handshake. It goes high on the
//   cycle after operand B is captured and stays high while resultado/carry
//   hold the sum of the a/b currently presented. It drops on the same edge
//   that loads a new operand A, on clr and on reset. There is no ready; the
//   consumer (a display) samples whenever it likes.
//
//   Modports: slave = carrega_operandos, master = environment / board side.
// ---------------------------------------------------------------------------
interface carrega_operandos_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] sw;
   logic             btn;
   logic             clr;
   logic [WIDTH-1:0] soma_in;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] resultado;
   logic             carry;
   logic             valid;
   logic [1:0]       estado;
`ifdef SOMA_CHECK_EN
   logic             erro;
`endif

   modport slave (
      input  sw, btn, clr, soma_in,
      output a, b, resultado, carry, valid, estado
`ifdef SOMA_CHECK_EN
      , output erro
`endif
   );

   modport master (
      output sw, btn, clr, soma_in,
      input  a, b, resultado, carry, valid, estado
`ifdef SOMA_CHECK_EN
      , input erro
`endif
   );
endinterface

// File: rtl/carrega_operandos.sv
// ---------------------------------------------------------------------------
// carrega_operandos
//   Operand-loading front end for the combinational adder somador.
//   Operand A and then operand B are captured from the switches on
//   successive key presses; both are driven to the adder as registered
//   values, and the adder's sum plus the carry-out are registered for display.
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    carrega_operandos_if.slave (sw, btn, clr, soma_in in;
//            a, b, resultado, carry, valid, estado [, erro] out)
//
//   Parameter:
//     WIDTH  operand/sum width, must match the adder
//
//   Optional feature (macro SOMA_CHECK_EN):
//     adds bus.erro, set in CALC when soma_in differs from (a+b) mod 2^WIDTH;
//     held until the next CALC, clr or reset.
// ---------------------------------------------------------------------------
module carrega_operandos #(
   parameter int WIDTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   carrega_operandos_if.slave  bus
);

   typedef enum logic [1:0] {
      ESPERA_A = 2'b00,
      ESPERA_B = 2'b01,
      CALC     = 2'b10,
      MOSTRA   = 2'b11
   } estado_t;

   estado_t          st;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] res_r;
   logic             carry_r;
   logic             valid_r;

   // Key synchroniser: s1/s2 resolve metastability, s3 is the previous
   // synchronised level so tecla fires once on each rising edge of btn.
   logic s1, s2, s3;
   logic tecla;

   // Carry needs one extra bit; the low bits double as the reference sum
   // for the optional adder check.
   logic [WIDTH:0] soma_ext;

   assign tecla    = s2 & ~s3;
   assign soma_ext = {1'b0, a_r} + {1'b0, b_r};

   // The synchroniser ignores clr on purpose so a key held across a clear
   // does not produce a spurious pulse afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= bus.btn;
         s2 <= s1;
         s3 <= s2;
      end
   end

`ifdef SOMA_CHECK_EN
   logic erro_r;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st      <= ESPERA_A;
         a_r     <= '0;
         b_r     <= '0;
         res_r   <= '0;
         carry_r <= 1'b0;
         valid_r <= 1'b0;
`ifdef SOMA_CHECK_EN
         erro_r  <= 1'b0;
`endif
      end else if (bus.clr) begin
         // clr wins over a key pulse on the same edge
         st      <= ESPERA_A;
         a_r     <= '0;
         b_r     <= '0;
         res_r   <= '0;
         carry_r <= 1'b0;
         valid_r <= 1'b0;
`ifdef SOMA_CHECK_EN
         erro_r  <= 1'b0;
`endif
      end else begin
         case (st)
            ESPERA_A: begin
               if (tecla) begin
                  a_r     <= bus.sw;
                  valid_r <= 1'b0;
                  st      <= ESPERA_B;
               end
            end
            ESPERA_B: begin
               if (tecla) begin
                  b_r <= bus.sw;
                  st  <= CALC;
               end
            end
            CALC: begin
               // a/b have been stable for a full cycle, so the adder has
               // settled and soma_in can be captured.
               res_r   <= bus.soma_in;
               carry_r <= soma_ext[WIDTH];
               valid_r <= 1'b1;
`ifdef SOMA_CHECK_EN
               erro_r  <= (bus.soma_in != soma_ext[WIDTH-1:0]);
`endif
               st      <= MOSTRA;
            end
            MOSTRA: begin
               // a press here starts the next pair directly with a new A
               if (tecla) begin
                  a_r     <= bus.sw;
                  valid_r <= 1'b0;
                  st      <= ESPERA_B;
               end
            end
            default: st <= ESPERA_A;
         endcase
      end
   end

   assign bus.a         = a_r;
   assign bus.b         = b_r;
   assign bus.resultado = res_r;
   assign bus.carry     = carry_r;
   assign bus.valid     = valid_r;
   assign bus.estado    = st;
`ifdef SOMA_CHECK_EN
   assign bus.erro      = erro_r;
`endif

endmodule

// File: tb/tb_carrega_operandos.sv
// ---------------------------------------------------------------------------
// tb_carrega_operandos
//   Bench for carrega_operandos. A behavioural adder closes the loop from
//   a/b back to soma_in. Each completed operand pair pushes its expected
//   {carry, resultado} into exp_q; a monitor pops and compares on every
//   rising edge of valid.
// ---------------------------------------------------------------------------
module tb_carrega_operandos;
   localparam int WIDTH = 4;
   localparam int MODV  = 1 << WIDTH;

   logic clk;
   logic rst_n;
   logic bad_adder;

   int n_cmp;
   int n_err;

   logic [WIDTH:0] exp_q[$];

   carrega_operandos_if #(.WIDTH(WIDTH)) bus ();

   carrega_operandos #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // behavioural adder; bad_adder injects an off-by-one fault
   assign bus.soma_in = WIDTH'((int'(bus.a) + int'(bus.b) + int'(bad_adder)) % MODV);

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: compare on each rising edge of valid
   logic prev_valid;
   initial prev_valid = 1'b0;
   always @(negedge clk) begin
      if (bus.valid && !prev_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            logic [WIDTH:0] e;
            e = exp_q.pop_front();
            check("sb_resultado", int'(bus.resultado), int'(e[WIDTH-1:0]));
            check("sb_carry", int'(bus.carry), int'(e[WIDTH]));
         end
      end
      prev_valid = bus.valid;
   end

   // ---------------- drivers ----------------
   // Raises btn before edge k; returns 1 time unit after edge k+2, where
   // the load has taken effect.
   task automatic press(input int v);
      @(negedge clk);
      bus.sw  = WIDTH'(v);
      bus.btn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Drops btn, scrambles sw, and lets the synchroniser settle.
   task automatic release_key();
      @(negedge clk);
      bus.btn = 1'b0;
      bus.sw  = WIDTH'($urandom_range(0, MODV - 1));
      repeat (4) @(posedge clk);
      #1;
   endtask

   // Loads one pair and checks the handshake timing directly; the sum
   // itself is checked by the monitor.
   task automatic load_pair(input int va, input int vb);
      int s;
      press(va);
      check("a_loaded", int'(bus.a), va);
      check("estado_after_a", int'(bus.estado), 1);
      check("valid_low_after_a", int'(bus.valid), 0);
      release_key();
      press(vb);
      s = (va + vb + int'(bad_adder)) % MODV;
      exp_q.push_back({((va + vb) >= MODV) ? 1'b1 : 1'b0, WIDTH'(s)});
      check("b_loaded", int'(bus.b), vb);
      check("a_kept", int'(bus.a), va);
      check("estado_calc", int'(bus.estado), 2);
      check("valid_low_in_calc", int'(bus.valid), 0);
      @(posedge clk);
      #1;
      check("valid_latency", int'(bus.valid), 1);
      check("estado_mostra", int'(bus.estado), 3);
      release_key();
      check("mostra_held", int'(bus.estado), 3);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_a"}, int'(bus.a), 0);
      check({tag, "_b"}, int'(bus.b), 0);
      check({tag, "_resultado"}, int'(bus.resultado), 0);
      check({tag, "_carry"}, int'(bus.carry), 0);
      check({tag, "_valid"}, int'(bus.valid), 0);
      check({tag, "_estado"}, int'(bus.estado), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      bad_adder = 1'b0;
      bus.btn   = 1'b0;
      bus.clr   = 1'b0;
      bus.sw    = '0;

      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
`ifdef SOMA_CHECK_EN
      check("reset_erro", int'(bus.erro), 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("idle_after_reset", int'(bus.estado), 0);

      // directed pairs, including the carry boundaries
      load_pair(2, 3);
      load_pair(15, 1);
      load_pair(9, 8);
      load_pair(8, 8);
      load_pair(0, 0);
      load_pair(15, 15);

      // random pairs
      for (int i = 0; i < 12; i++) begin
         load_pair(int'($urandom_range(0, MODV - 1)), int'($urandom_range(0, MODV - 1)));
      end

      // clr from MOSTRA returns everything to reset values
      @(negedge clk);
      bus.clr = 1'b1;
      @(negedge clk);
      bus.clr = 1'b0;
      #1;
      check_all_zero("clr_mostra");

      // key held for 20 cycles gives exactly one load
      @(negedge clk);
      bus.sw  = 4'd6;
      bus.btn = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("hold_a", int'(bus.a), 6);
      check("hold_estado", int'(bus.estado), 1);
      check("hold_valid", int'(bus.valid), 0);

      // switch activity without a key pulse has no effect
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.sw = WIDTH'($urandom_range(0, MODV - 1));
      end
      #1;
      check("sw_noise_a", int'(bus.a), 6);
      check("sw_noise_b", int'(bus.b), 0);
      check("sw_noise_estado", int'(bus.estado), 1);
      release_key();

      // clr coinciding with the pulse that would load B
      @(negedge clk);
      bus.sw  = 4'd9;
      bus.btn = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      bus.clr = 1'b1;
      @(posedge clk);
      #1;
      check_all_zero("clr_vs_key");
      @(negedge clk);
      bus.clr = 1'b0;
      bus.btn = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("clr_no_late_pulse", int'(bus.estado), 0);

      // async reset while in CALC
      press(10);
      check("rst_test_a", int'(bus.a), 10);
      release_key();
      press(5);
      check("rst_test_calc", int'(bus.estado), 2);
      rst_n = 1'b0;
      #1;
      check_all_zero("rst_in_calc");
      bus.btn = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_release_estado", int'(bus.estado), 0);
      check("rst_release_valid", int'(bus.valid), 0);
      repeat (4) @(posedge clk);
      #1;
      check("rst_release_idle", int'(bus.estado), 0);
      check("rst_release_valid2", int'(bus.valid), 0);

`ifdef SOMA_CHECK_EN
      bad_adder = 1'b1;
      load_pair(6, 8);
      check("erro_set", int'(bus.erro), 1);
      bad_adder = 1'b0;
      load_pair(0, 1);
      check("erro_clear", int'(bus.erro), 0);
`endif

      // a pair after all the disturbances still works
      load_pair(7, 9);

      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // global time bound
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, got 1 expected 0");
      n_err++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "timeout");
   end

endmodule
